// File: rtl/baccarat_round_controller.sv
// Purpose: round sequencer above the baccarat game FSM; takes a bet, runs one game, settles it.
// Latency: start at edge k -> CHECK k+1, CLEAR k+2, PLAY (game_resetb=1) from k+3; balance updates leaving SETTLE.
// Backpressure: start is only looked at in IDLE; requests while busy are dropped, never queued.
module baccarat_round_controller #(
  parameter int BAL_W         = 8,
  parameter int START_BALANCE = 100,
  parameter int GAME_TIMEOUT  = 15
) (
  input  logic             slow_clock,
  input  logic             reset,
  input  logic             start,
  input  logic [BAL_W-1:0] bet,
  input  logic             player_win_light,
  input  logic             dealer_win_light,
  output logic             game_resetb,
  output logic             busy,
  output logic [BAL_W-1:0] balance,
  output logic [7:0]       round_count,
  output logic [7:0]       player_wins,
  output logic [7:0]       dealer_wins,
  output logic [7:0]       draws,
  output logic             bet_err,
  output logic             timeout_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_PLAY   = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;

  // Timer only needs to reach GAME_TIMEOUT-1.
  localparam int TMR_W = (GAME_TIMEOUT > 2) ? $clog2(GAME_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GAME_TIMEOUT - 1);

  logic [2:0]       state;
  logic [BAL_W-1:0] bet_q;
  logic [TMR_W-1:0] timer;
  logic             p_light_q;
  logic             d_light_q;
  logic [BAL_W:0]   win_sum;
  logic [BAL_W-1:0] win_bal;
  logic             any_light;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Moore decodes: the game FSM only runs in PLAY.
  assign game_resetb = (state == S_PLAY);
  assign busy        = (state != S_IDLE);
  assign any_light   = player_win_light | dealer_win_light;

  // Player-win balance, clamped at the top of the balance range.
  always_comb begin
    win_sum = {1'b0, balance} + {1'b0, bet_q};
    win_bal = win_sum[BAL_W] ? {BAL_W{1'b1}} : win_sum[BAL_W-1:0];
  end

  // Round sequencing, settlement and tallies; reset discards any round in flight.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state       <= S_IDLE;
      bet_q       <= '0;
      timer       <= '0;
      p_light_q   <= 1'b0;
      d_light_q   <= 1'b0;
      balance     <= BAL_W'(START_BALANCE);
      round_count <= '0;
      player_wins <= '0;
      dealer_wins <= '0;
      draws       <= '0;
      bet_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            bet_q <= bet;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Zero or unaffordable bets never reach the game, so SETTLE cannot underflow.
          if ((bet_q == '0) || (bet_q > balance)) begin
            bet_err <= 1'b1;
            state   <= S_IDLE;
          end else begin
            bet_err <= 1'b0;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          timer       <= '0;
          timeout_err <= 1'b0;
          state       <= S_PLAY;
        end
        S_PLAY: begin
          timer <= timer + 1'b1;
          if (any_light) begin
            p_light_q <= player_win_light;
            d_light_q <= dealer_win_light;
            state     <= S_SETTLE;
          end else if (timer == TMR_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_SETTLE: begin
          round_count <= sat_inc(round_count);
          if (p_light_q && d_light_q) begin
            draws <= sat_inc(draws);
          end else if (p_light_q) begin
            balance     <= win_bal;
            player_wins <= sat_inc(player_wins);
          end else begin
            balance     <= balance - bet_q;
            dealer_wins <= sat_inc(dealer_wins);
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_baccarat_round_controller.sv
// Purpose: randomized bench for baccarat_round_controller against a round-level reference model.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: start is toggled randomly during PLAY to confirm it is ignored.
module tb_baccarat_round_controller;

  logic       slow_clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] bet;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       game_resetb;
  logic       busy;
  logic [7:0] balance;
  logic [7:0] round_count;
  logic [7:0] player_wins;
  logic [7:0] dealer_wins;
  logic [7:0] draws;
  logic       bet_err;
  logic       timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the round's observable bookkeeping.
  int m_bal, m_rc, m_pw, m_dw, m_dr;
  int m_berr, m_terr;

  always #5 slow_clock = ~slow_clock;

  baccarat_round_controller #(
    .BAL_W(8), .START_BALANCE(100), .GAME_TIMEOUT(15)
  ) dut (
    .slow_clock      (slow_clock),
    .reset           (reset),
    .start           (start),
    .bet             (bet),
    .player_win_light(player_win_light),
    .dealer_win_light(dealer_win_light),
    .game_resetb     (game_resetb),
    .busy            (busy),
    .balance         (balance),
    .round_count     (round_count),
    .player_wins     (player_wins),
    .dealer_wins     (dealer_wins),
    .draws           (draws),
    .bet_err         (bet_err),
    .timeout_err     (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge slow_clock);
    #1;
  endtask

  function automatic int sat8(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, ".balance"},     balance,     m_bal);
    chk({tag, ".round_count"}, round_count, m_rc);
    chk({tag, ".player_wins"}, player_wins, m_pw);
    chk({tag, ".dealer_wins"}, dealer_wins, m_dw);
    chk({tag, ".draws"},       draws,       m_dr);
    chk({tag, ".bet_err"},     bet_err,     m_berr);
    chk({tag, ".timeout_err"}, timeout_err, m_terr);
    chk({tag, ".busy"},        busy,        0);
    chk({tag, ".game_resetb"}, game_resetb, 0);
  endtask

  task automatic model_reset();
    m_bal = 100; m_rc = 0; m_pw = 0; m_dw = 0; m_dr = 0;
    m_berr = 0; m_terr = 0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; start = 1'b0; player_win_light = 1'b0; dealer_win_light = 1'b0;
    step();
    reset = 1'b0;
    model_reset();
    check_idle(tag);
  endtask

  // outc: 0 = no lights (timeout), 1 = player, 2 = dealer, 3 = both (draw).
  // d: PLAY cycles with lights low before the lights come on.
  task automatic run_round(input string tag, input int b, input int outc, input int d, input bit spam);
    start = 1'b1; bet = 8'(b);
    step();                                   // edge k: IDLE -> CHECK
    start = 1'b0; bet = 8'($urandom);         // bet must have been captured already
    chk({tag, ".chk_busy"}, busy, 1);
    chk({tag, ".chk_grb"},  game_resetb, 0);
    step();                                   // edge k+1: CHECK -> CLEAR or IDLE
    if (b == 0 || b > m_bal) begin
      m_berr = 1;
      check_idle({tag, ".rej"});
      return;
    end
    m_berr = 0;
    chk({tag, ".clr_grb"},  game_resetb, 0);
    chk({tag, ".clr_busy"}, busy, 1);
    chk({tag, ".clr_berr"}, bet_err, 0);
    step();                                   // edge k+2: CLEAR -> PLAY
    m_terr = 0;
    chk({tag, ".play_grb"},  game_resetb, 1);
    chk({tag, ".play_terr"}, timeout_err, 0);
    if (outc == 0) begin
      for (int i = 0; i < 15; i++) begin
        start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        if (i < 14) chk({tag, ".tmo_play"}, game_resetb, 1);
      end
      start = 1'b0;
      m_terr = 1;
      check_idle({tag, ".tmo"});
      return;
    end
    for (int i = 0; i < d; i++) begin
      start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      chk({tag, ".wait_grb"}, game_resetb, 1);
    end
    start = 1'b0;
    player_win_light = outc[0];
    dealer_win_light = outc[1];
    step();                                   // PLAY -> SETTLE
    chk({tag, ".set_grb"},  game_resetb, 0);
    chk({tag, ".set_busy"}, busy, 1);
    player_win_light = 1'b0;                  // settlement must use the captured lights
    dealer_win_light = 1'b0;
    step();                                   // SETTLE -> IDLE
    m_rc = sat8(m_rc);
    if (outc == 3) m_dr = sat8(m_dr);
    else if (outc == 1) begin
      m_pw  = sat8(m_pw);
      m_bal = (m_bal + b > 255) ? 255 : m_bal + b;
    end else begin
      m_dw  = sat8(m_dw);
      m_bal = m_bal - b;
    end
    check_idle({tag, ".settled"});
  endtask

  task automatic reset_in_play(input string tag);
    start = 1'b1; bet = 8'd1;
    step(); start = 1'b0;
    step(); step();
    step(); step();
    chk({tag, ".in_play"}, game_resetb, 1);
    player_win_light = 1'b1;                  // reset must win over the light
    reset = 1'b1;
    step();
    reset = 1'b0;
    player_win_light = 1'b0;
    model_reset();
    check_idle(tag);
    step();
    check_idle({tag, ".after"});
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; bet = '0;
    player_win_light = 1'b0; dealer_win_light = 1'b0;
    model_reset();
    step();
    do_reset("rst0");

    // Directed rounds.
    run_round("p10",   10,  1, 3, 1'b0);      // 110
    run_round("d110",  110, 2, 5, 1'b0);      // 0
    run_round("b1",    1,   1, 0, 1'b0);      // rejected at zero balance
    do_reset("rst1");
    run_round("draw",  20,  3, 4, 1'b0);
    run_round("bet0",  0,   1, 0, 1'b0);
    run_round("ok30",  30,  2, 2, 1'b0);      // clears bet_err
    run_round("tmo",   5,   0, 0, 1'b1);
    run_round("after", 5,   1, 0, 1'b0);      // clears timeout_err
    do_reset("rst2");
    run_round("w100",  100, 1, 6, 1'b1);      // 200
    run_round("w200",  200, 1, 12, 1'b1);     // saturates at 255
    run_round("p1",    1,   1, 1, 1'b0);
    reset_in_play("rstplay");

    // Randomized rounds.
    for (int it = 0; it < 60; it++) begin
      int b, outc, d;
      if (m_bal == 0 || $urandom_range(0, 9) == 0) do_reset("rrst");
      if (it % 17 == 16) reset_in_play("rplay");
      b    = $urandom_range(0, (m_bal + 10 > 255) ? 255 : m_bal + 10);
      outc = $urandom_range(0, 3);
      d    = $urandom_range(0, 12);
      run_round("rnd", b, outc, d, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
